// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
//   REG_ADDR / REG_WIDTH : register index and data types
//   bool                 : single-bit flag type
//   CMT_REQUIRE          : {write_reg_need, write_reg_addr, result} handed to commit
//   ROB_ENTRY            : per-entry state held in the reorder buffer
//   ROB_DEPTH            : default number of entries
package reorder_buffer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned ROB_DEPTH  = 16;

  typedef logic bool;
  typedef logic [REG_ADDR_W-1:0] REG_ADDR;
  typedef logic [REG_DATA_W-1:0] REG_WIDTH;

  typedef struct packed {
    bool      write_reg_need;
    REG_ADDR  write_reg_addr;
    REG_WIDTH result;
  } CMT_REQUIRE;

  typedef struct packed {
    bool      valid;
    bool      done;
    bool      write_reg_need;
    REG_ADDR  write_reg_addr;
    REG_WIDTH result;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_commit_select.sv
// Combinational commit selection for the two oldest reorder-buffer entries.
//   head_entry  : entry at head (possibly with same-cycle writeback folded in)
//   next_entry  : entry at head+1
//   kill        : flush/reset this cycle, suppresses all commits
//   cmt_require : per-slot commit payload, zero when the slot is not selected
//   cmt_count   : number of selected slots (0..2)
module rob_commit_select
  import reorder_buffer_pkg::*;
(
  input  ROB_ENTRY         head_entry,
  input  ROB_ENTRY         next_entry,
  input  logic             kill,
  output CMT_REQUIRE [1:0] cmt_require,
  output logic [1:0]       cmt_count
);

  logic sel0;
  logic sel1;

  always_comb begin
    sel0 = !kill && head_entry.valid && head_entry.done;
    // Only one regfile write port: never pair two register-writing entries.
    sel1 = sel0 && next_entry.valid && next_entry.done &&
           !(head_entry.write_reg_need && next_entry.write_reg_need);

    cmt_require = '0;
    if (sel0) begin
      cmt_require[0].write_reg_need = head_entry.write_reg_need;
      cmt_require[0].write_reg_addr = head_entry.write_reg_addr;
      cmt_require[0].result         = head_entry.result;
    end
    if (sel1) begin
      cmt_require[1].write_reg_need = next_entry.write_reg_need;
      cmt_require[1].write_reg_addr = next_entry.write_reg_addr;
      cmt_require[1].result         = next_entry.result;
    end

    // sel1 implies sel0, so the count is 2, 1 or 0.
    cmt_count = {sel1, sel0 & ~sel1};
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer for the dual-issue pipeline.
// Up to 2 allocations and 2 writebacks per cycle; up to 2 in-order commits per cycle,
// at most one of which writes a register.
//   clk, rst (sync, active high), flush          : control
//   alloc_valid/_write_reg_need/_write_reg_addr  : dispatch requests
//   alloc_ready, alloc_tag                       : at least 2 free entries, tags tail/tail+1
//   wb_valid, wb_tag, wb_result                  : execute writebacks
//   cmt_require, cmt_count                       : entries committing this cycle
//   empty, full                                  : occupancy status
// Build option: define ROB_BYPASS_EN to let a same-cycle writeback to head/head+1
// count as done for commit selection.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            alloc_valid,
  input  bool [1:0]             alloc_write_reg_need,
  input  REG_ADDR [1:0]         alloc_write_reg_addr,
  output logic                  alloc_ready,
  output logic [1:0][TAG_W-1:0] alloc_tag,
  input  logic [1:0]            wb_valid,
  input  logic [1:0][TAG_W-1:0] wb_tag,
  input  REG_WIDTH [1:0]        wb_result,
  output CMT_REQUIRE [1:0]      cmt_require,
  output logic [1:0]            cmt_count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [TAG_W:0]   AllocLimit = (TAG_W+1)'(DEPTH - 2);
  localparam logic [TAG_W:0]   FullCount  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] TagOne     = TAG_W'(1);

  ROB_ENTRY         rob_q [DEPTH];
  ROB_ENTRY         rob_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [TAG_W-1:0] head_nxt;
  logic [TAG_W-1:0] tail_nxt;
  logic [1:0]       n_alloc;
  ROB_ENTRY         sel_ent0;
  ROB_ENTRY         sel_ent1;

  assign head_nxt     = head_q + TagOne;
  assign tail_nxt     = tail_q + TagOne;
  // Judged on the current count only; a commit in the same cycle does not free space early.
  assign alloc_ready  = (count_q <= AllocLimit);
  assign alloc_tag[0] = tail_q;
  assign alloc_tag[1] = tail_nxt;
  assign empty        = (count_q == '0);
  assign full         = (count_q == FullCount);

  always_comb begin
    n_alloc = 2'd0;
    if (alloc_ready) begin
      case (alloc_valid)
        2'b01:   n_alloc = 2'd1;
        2'b11:   n_alloc = 2'd2;
        default: n_alloc = 2'd0;
      endcase
    end
  end

  // View of the two oldest entries presented to commit selection.
  always_comb begin
    sel_ent0 = rob_q[head_q];
    sel_ent1 = rob_q[head_nxt];
`ifdef ROB_BYPASS_EN
    // Later slot overrides, so slot1 wins a tag clash.
    for (int i = 0; i < 2; i++) begin
      if (wb_valid[i] && (wb_tag[i] == head_q) && sel_ent0.valid) begin
        sel_ent0.done   = 1'b1;
        sel_ent0.result = wb_result[i];
      end
      if (wb_valid[i] && (wb_tag[i] == head_nxt) && sel_ent1.valid) begin
        sel_ent1.done   = 1'b1;
        sel_ent1.result = wb_result[i];
      end
    end
`endif
  end

  rob_commit_select u_commit_select (
    .head_entry  (sel_ent0),
    .next_entry  (sel_ent1),
    .kill        (rst | flush),
    .cmt_require (cmt_require),
    .cmt_count   (cmt_count)
  );

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_d[i].valid = 1'b0;
        rob_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wb_valid[i] && rob_q[wb_tag[i]].valid) begin
          rob_d[wb_tag[i]].done   = 1'b1;
          rob_d[wb_tag[i]].result = wb_result[i];
        end
      end
      if (cmt_count != 2'd0) begin
        rob_d[head_q].valid = 1'b0;
        rob_d[head_q].done  = 1'b0;
      end
      if (cmt_count == 2'd2) begin
        rob_d[head_nxt].valid = 1'b0;
        rob_d[head_nxt].done  = 1'b0;
      end
      // Allocation slots are free by construction, so this cannot clobber a live entry.
      if (n_alloc != 2'd0) begin
        rob_d[tail_q].valid          = 1'b1;
        rob_d[tail_q].done           = 1'b0;
        rob_d[tail_q].write_reg_need = alloc_write_reg_need[0];
        rob_d[tail_q].write_reg_addr = alloc_write_reg_addr[0];
        rob_d[tail_q].result         = '0;
      end
      if (n_alloc == 2'd2) begin
        rob_d[tail_nxt].valid          = 1'b1;
        rob_d[tail_nxt].done           = 1'b0;
        rob_d[tail_nxt].write_reg_need = alloc_write_reg_need[1];
        rob_d[tail_nxt].write_reg_addr = alloc_write_reg_addr[1];
        rob_d[tail_nxt].result         = '0;
      end
      head_d  = head_q + TAG_W'(cmt_count);
      tail_d  = tail_q + TAG_W'(n_alloc);
      count_d = count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(cmt_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= rob_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [1:0]            alloc_valid;
  bool [1:0]             alloc_write_reg_need;
  REG_ADDR [1:0]         alloc_write_reg_addr;
  logic                  alloc_ready;
  logic [1:0][TAG_W-1:0] alloc_tag;
  logic [1:0]            wb_valid;
  logic [1:0][TAG_W-1:0] wb_tag;
  REG_WIDTH [1:0]        wb_result;
  CMT_REQUIRE [1:0]      cmt_require;
  logic [1:0]            cmt_count;
  logic                  empty;
  logic                  full;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .alloc_valid          (alloc_valid),
    .alloc_write_reg_need (alloc_write_reg_need),
    .alloc_write_reg_addr (alloc_write_reg_addr),
    .alloc_ready          (alloc_ready),
    .alloc_tag            (alloc_tag),
    .wb_valid             (wb_valid),
    .wb_tag               (wb_tag),
    .wb_result            (wb_result),
    .cmt_require          (cmt_require),
    .cmt_count            (cmt_count),
    .empty                (empty),
    .full                 (full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: live tags in program order plus per-tag contents.
  int          order_q[$];
  bit          m_alive[DEPTH];
  bit          m_done[DEPTH];
  bit          m_need[DEPTH];
  logic [4:0]  m_addr[DEPTH];
  logic [31:0] m_res[DEPTH];
  int          m_tail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    order_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_alive[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_tail = 0;
  endfunction

  function automatic void model_wb();
    for (int i = 0; i < 2; i++) begin
      if (wb_valid[i] && m_alive[wb_tag[i]]) begin
        m_done[wb_tag[i]] = 1'b1;
        m_res[wb_tag[i]]  = wb_result[i];
      end
    end
  endfunction

  // Monitor + scoreboard: compares DUT outputs with the model, then advances the model
  // by what the coming clock edge should do.
  always @(negedge clk) begin
    int         exp_n;
    int         t;
    bit         was_ready;
    int         n_new;
    CMT_REQUIRE exp_slot;
    if (rst) begin
      model_reset();
    end else begin
      check("empty", 64'(empty), 64'(order_q.size() == 0));
      check("full", 64'(full), 64'(order_q.size() == DEPTH));
      check("alloc_ready", 64'(alloc_ready), 64'(order_q.size() <= DEPTH - 2));
      check("alloc_tag0", 64'(alloc_tag[0]), 64'(m_tail));
      check("alloc_tag1", 64'(alloc_tag[1]), 64'((m_tail + 1) % DEPTH));
`ifdef ROB_BYPASS_EN
      if (!flush) model_wb();
`endif
      exp_n = 0;
      if (!flush && order_q.size() > 0 && m_done[order_q[0]]) begin
        exp_n = 1;
        if (order_q.size() > 1 && m_done[order_q[1]] &&
            !(m_need[order_q[0]] && m_need[order_q[1]])) exp_n = 2;
      end
      check("cmt_count", 64'(cmt_count), 64'(exp_n));
      for (int s = 0; s < 2; s++) begin
        exp_slot = '0;
        if (s < exp_n) begin
          t = order_q[s];
          exp_slot.write_reg_need = m_need[t];
          exp_slot.write_reg_addr = m_addr[t];
          exp_slot.result         = m_res[t];
        end
        check($sformatf("cmt_require%0d", s), 64'(cmt_require[s]), 64'(exp_slot));
      end
      if (flush) begin
        model_reset();
      end else begin
`ifndef ROB_BYPASS_EN
        model_wb();
`endif
        was_ready = (order_q.size() <= DEPTH - 2);
        repeat (exp_n) begin
          t = order_q.pop_front();
          m_alive[t] = 1'b0;
          m_done[t]  = 1'b0;
        end
        if (was_ready && alloc_valid[0]) begin
          n_new = alloc_valid[1] ? 2 : 1;
          for (int k = 0; k < n_new; k++) begin
            order_q.push_back(m_tail);
            m_alive[m_tail] = 1'b1;
            m_done[m_tail]  = 1'b0;
            m_need[m_tail]  = alloc_write_reg_need[k];
            m_addr[m_tail]  = alloc_write_reg_addr[k];
            m_res[m_tail]   = '0;
            m_tail = (m_tail + 1) % DEPTH;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    flush = 1'b0;
    alloc_valid = 2'b00;
    alloc_write_reg_need = 2'b00;
    alloc_write_reg_addr = '0;
    wb_valid = 2'b00;
    wb_tag = '0;
    wb_result = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic alloc2(input bit n0, input int a0, input bit n1, input int a1);
    alloc_valid = 2'b11;
    alloc_write_reg_need = {n1, n0};
    alloc_write_reg_addr[0] = 5'(a0);
    alloc_write_reg_addr[1] = 5'(a1);
  endtask

  task automatic wb1(input int slot, input int tag, input int val);
    wb_valid[slot] = 1'b1;
    wb_tag[slot] = TAG_W'(tag);
    wb_result[slot] = 32'(val);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
    step(2);

    // Two register writers completed out of order commit one per cycle.
    alloc2(1'b1, 3, 1'b1, 4);
    step(1);
    idle_inputs();
    wb1(0, 1, 'h22);
    step(1);
    idle_inputs();
    wb1(0, 0, 'h11);
    step(1);
    idle_inputs();
    step(4);

    // Writer + non-writer commit together.
    alloc2(1'b1, 5, 1'b0, 9);
    step(1);
    idle_inputs();
    wb1(0, order_q[0], 'h55);
    wb1(1, order_q[1], 'h66);
    step(1);
    idle_inputs();
    step(3);

    // Fill to full from tag 0, try to overflow, then commit 2 and wrap.
    flush = 1'b1;
    step(1);
    idle_inputs();
    while (order_q.size() < DEPTH) begin
      alloc2(1'b0, 1, 1'b0, 2);
      step(1);
    end
    alloc2(1'b1, 7, 1'b1, 8);
    step(1);
    wb1(0, order_q[0], 'hA0);
    wb1(1, order_q[1], 'hA1);
    step(1);
    wb_valid = 2'b00;
    step(3);
    idle_inputs();
    for (int i = 0; i < DEPTH; i += 2) begin
      if (order_q.size() > i + 1) begin
        wb1(0, order_q[i], i);
        wb1(1, order_q[i + 1], i + 1);
      end
      step(1);
    end
    idle_inputs();
    step(10);

    // Flush with done entries and a simultaneous allocation.
    flush = 1'b1;
    step(1);
    idle_inputs();
    alloc2(1'b1, 1, 1'b1, 2);
    step(3);
    idle_inputs();
    wb1(0, 5, 'h5);
    wb1(1, 4, 'h4);
    step(1);
    wb1(0, 3, 'h3);
    wb1(1, 2, 'h2);
    step(1);
    wb1(0, 1, 'h1);
    wb1(1, 0, 'h0);
    step(1);
    idle_inputs();
    flush = 1'b1;
    alloc2(1'b1, 6, 1'b1, 7);
    step(1);
    idle_inputs();
    step(2);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(499) == 0);
      flush = ($urandom_range(79) == 0);
      alloc_valid = 2'($urandom_range(3));
      alloc_write_reg_need = 2'($urandom);
      alloc_write_reg_addr[0] = 5'($urandom);
      alloc_write_reg_addr[1] = 5'($urandom);
      for (int i = 0; i < 2; i++) begin
        wb_valid[i] = ($urandom_range(2) != 0);
        if (order_q.size() > 0 && $urandom_range(5) != 0)
          wb_tag[i] = TAG_W'(order_q[$urandom_range(order_q.size() - 1)]);
        else
          wb_tag[i] = TAG_W'($urandom);
        wb_result[i] = $urandom;
      end
      step(1);
    end
    rst = 1'b0;
    idle_inputs();
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
